// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and sizing for the pipeline hazard controller.
//   NUM_REGS / REG_IDX_W : architectural register file size / index width
//   DBITS                : PC / branch target width
//   MAX_INFLIGHT / CNT_W : max outstanding writes per register and counter width
//   hz_state_e           : branch-resolution FSM encoding
package pipeline_hazard_ctrl_pkg;
   localparam int NUM_REGS     = 32;
   localparam int REG_IDX_W    = 5;
   localparam int DBITS        = 32;
   localparam int MAX_INFLIGHT = 3;
   localparam int CNT_W        = 2;

   typedef enum logic [1:0] {
      HZ_IDLE     = 2'd0,
      HZ_BR_WAIT  = 2'd1,
      HZ_REDIRECT = 2'd2
   } hz_state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline stages and the hazard controller.
//   master : pipeline side (drives DE/AGEX/WB status, receives stall/flush/redirect)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if;
   import pipeline_hazard_ctrl_pkg::*;

   // DE stage
   logic                 de_valid;
   logic [REG_IDX_W-1:0] de_rs1;
   logic [REG_IDX_W-1:0] de_rs2;
   logic                 de_rs1_used;
   logic                 de_rs2_used;
   logic [REG_IDX_W-1:0] de_rd;
   logic                 de_wr_reg;
   logic                 de_is_branch;
   // AGEX branch resolution
   logic                 agex_br_valid;
   logic                 agex_br_taken;
   logic [DBITS-1:0]     agex_br_target;
   // WB retirement
   logic                 wb_valid;
   logic                 wb_wr_reg;
   logic [REG_IDX_W-1:0] wb_rd;
   // controller outputs
   logic                 de_issue;
   logic                 stall_fe;
   logic                 stall_de;
   logic                 flush_de;
   logic                 redirect_valid;
   logic [DBITS-1:0]     redirect_target;

   modport master (
      output de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd, de_wr_reg,
             de_is_branch, agex_br_valid, agex_br_taken, agex_br_target,
             wb_valid, wb_wr_reg, wb_rd,
      input  de_issue, stall_fe, stall_de, flush_de, redirect_valid, redirect_target
   );

   modport slave (
      input  de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd, de_wr_reg,
             de_is_branch, agex_br_valid, agex_br_taken, agex_br_target,
             wb_valid, wb_wr_reg, wb_rd,
      output de_issue, stall_fe, stall_de, flush_de, redirect_valid, redirect_target
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hz_scoreboard: per-register count of issued-but-not-retired writes.
//   clk, reset          : clock, synchronous active-high reset
//   inc_i / inc_rd_i    : an instruction writing inc_rd_i issues
//   dec_i / dec_rd_i    : WB retires a write to dec_rd_i
//   rs1_i / rs2_i       : source lookups -> busy1_o / busy2_o
//   rd_i                : destination lookup -> sat_o (counter full)
module hz_scoreboard
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc_i,
   input  logic [REG_IDX_W-1:0] inc_rd_i,
   input  logic                 dec_i,
   input  logic [REG_IDX_W-1:0] dec_rd_i,
   input  logic [REG_IDX_W-1:0] rs1_i,
   input  logic [REG_IDX_W-1:0] rs2_i,
   input  logic [REG_IDX_W-1:0] rd_i,
   output logic                 busy1_o,
   output logic                 busy2_o,
   output logic                 sat_o
);
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_REGS-1:0]            inc_vec, dec_vec;

   // x0 is hard-wired, so it never enters the scoreboard
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (inc_i && inc_rd_i != '0) inc_vec[inc_rd_i] = 1'b1;
      if (dec_i && dec_rd_i != '0) dec_vec[dec_rd_i] = 1'b1;
   end

   always_comb begin
      cnt_d = cnt_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         unique case ({inc_vec[r], dec_vec[r]})
            2'b10:   cnt_d[r] = cnt_q[r] + CNT_W'(1);
            // underflow clamps to zero rather than wrapping
            2'b01:   cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - CNT_W'(1);
            default: cnt_d[r] = cnt_q[r];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // A retirement this cycle releases the register immediately (RF is write-first),
   // i.e. busy = (cnt - dec) != 0 without wrapping on an empty counter.
   assign busy1_o = (cnt_q[rs1_i] != '0) && !(cnt_q[rs1_i] == CNT_W'(1) && dec_vec[rs1_i]);
   assign busy2_o = (cnt_q[rs2_i] != '0) && !(cnt_q[rs2_i] == CNT_W'(1) && dec_vec[rs2_i]);
   assign sat_o   = (cnt_q[rd_i] == CNT_W'(MAX_INFLIGHT));

   always_ff @(posedge clk) begin
      if (!reset && dec_vec != '0)
         a_wb_underflow: assert (cnt_q[dec_rd_i] != '0);
   end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the FE/DE/AGEX/MEM/WB pipeline.
//   clk, reset : clock, synchronous active-high reset
//   hz         : slave side of pipeline_hazard_ctrl_if
//                in : DE operands/dest/branch flag, AGEX resolution, WB retirement
//                out: de_issue, stall_fe/stall_de, flush_de, redirect_valid/target
// RAW and write-count saturation hold DE; a branch freezes FE/DE until AGEX resolves
// it, and a taken branch yields a single-cycle redirect with a DE flush.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   pipeline_hazard_ctrl_if.slave   hz
);
   hz_state_e        state_q, state_d;
   logic [DBITS-1:0] tgt_q, tgt_d;
   logic             busy1, busy2, sat_raw;
   logic             raw, sat, issue;

   hz_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .inc_i    (issue & hz.de_wr_reg),
      .inc_rd_i (hz.de_rd),
      .dec_i    (hz.wb_valid & hz.wb_wr_reg),
      .dec_rd_i (hz.wb_rd),
      .rs1_i    (hz.de_rs1),
      .rs2_i    (hz.de_rs2),
      .rd_i     (hz.de_rd),
      .busy1_o  (busy1),
      .busy2_o  (busy2),
      .sat_o    (sat_raw)
   );

   assign raw   = (hz.de_rs1_used & busy1) | (hz.de_rs2_used & busy2);
   assign sat   = hz.de_wr_reg & sat_raw;
   // reset gating keeps every output quiet while reset is held
   assign issue = ~reset & hz.de_valid & ~raw & ~sat & (state_q == HZ_IDLE);

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      unique case (state_q)
         HZ_IDLE:
            if (issue && hz.de_is_branch) state_d = HZ_BR_WAIT;
         HZ_BR_WAIT:
            if (hz.agex_br_valid) begin
               if (hz.agex_br_taken) begin
                  tgt_d   = hz.agex_br_target;
                  state_d = HZ_REDIRECT;
               end else begin
                  state_d = HZ_IDLE;
               end
            end
         HZ_REDIRECT:
            state_d = HZ_IDLE;
         default:
            state_d = HZ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HZ_IDLE;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   // REDIRECT releases both stalls: FE takes the new PC while DE takes the bubble.
   assign hz.de_issue        = issue;
   assign hz.stall_de        = ~reset & ((state_q == HZ_BR_WAIT) |
                                         ((state_q == HZ_IDLE) & hz.de_valid & ~issue));
   assign hz.stall_fe        = hz.stall_de;
   assign hz.flush_de        = ~reset & (state_q == HZ_REDIRECT);
   assign hz.redirect_valid  = ~reset & (state_q == HZ_REDIRECT);
   assign hz.redirect_target = reset ? '0 : tgt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if hz ();

   pipeline_hazard_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   // ctl = {de_issue, stall_fe, stall_de, flush_de, redirect_valid}
   typedef struct {
      string            tag;
      logic [4:0]       ctl;
      bit               chk_tgt;
      logic [DBITS-1:0] tgt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // outputs are combinational from inputs driven at posedge+1; sample at negedge
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({e.tag, ".ctl"}, 64'({hz.de_issue, hz.stall_fe, hz.stall_de,
                                   hz.flush_de, hz.redirect_valid}), 64'(e.ctl));
         if (e.chk_tgt) chk({e.tag, ".tgt"}, 64'(hz.redirect_target), 64'(e.tgt));
      end
   end

   task automatic ex(input string tag, input logic iss, input logic stl, input logic fl,
                     input logic rv, input logic [DBITS-1:0] tgt = '0, input bit ct = 1'b0);
      exp_t e;
      e.tag = tag; e.ctl = {iss, stl, stl, fl, rv}; e.chk_tgt = ct; e.tgt = tgt;
      exp_q.push_back(e);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
      hz.de_valid = 1'b0; hz.de_rs1 = '0; hz.de_rs2 = '0; hz.de_rs1_used = 1'b0;
      hz.de_rs2_used = 1'b0; hz.de_rd = '0; hz.de_wr_reg = 1'b0; hz.de_is_branch = 1'b0;
      hz.agex_br_valid = 1'b0; hz.agex_br_taken = 1'b0; hz.agex_br_target = '0;
      hz.wb_valid = 1'b0; hz.wb_wr_reg = 1'b0; hz.wb_rd = '0;
   endtask

   task automatic de(input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wr, input bit br);
      hz.de_valid = 1'b1;
      hz.de_rs1 = REG_IDX_W'(rs1); hz.de_rs1_used = u1;
      hz.de_rs2 = REG_IDX_W'(rs2); hz.de_rs2_used = u2;
      hz.de_rd = REG_IDX_W'(rd); hz.de_wr_reg = wr; hz.de_is_branch = br;
   endtask

   task automatic wb(input int rd);
      hz.wb_valid = 1'b1; hz.wb_wr_reg = 1'b1; hz.wb_rd = REG_IDX_W'(rd);
   endtask

   task automatic br(input bit taken, input logic [DBITS-1:0] tgt);
      hz.agex_br_valid = 1'b1; hz.agex_br_taken = taken; hz.agex_br_target = tgt;
   endtask

   initial begin
      reset = 1'b1;
      nxt();
      // reset held with a valid DE instruction: everything quiet
      for (int i = 0; i < 3; i++) begin
         nxt(); de(5, 1, 6, 1, 5, 1, 0); ex($sformatf("rst%0d", i), 0, 0, 0, 0, '0, 1);
      end
      nxt(); reset = 1'b0; de(5, 1, 6, 1, 7, 0, 0); ex("rst.cnt0", 1, 0, 0, 0);

      // RAW on x5, released by a same-cycle WB
      nxt(); de(1, 1, 2, 1, 5, 1, 0); ex("raw.t0", 1, 0, 0, 0);
      nxt(); de(5, 1, 0, 0, 0, 0, 0); ex("raw.t1", 0, 1, 0, 0);
      nxt(); de(5, 1, 0, 0, 0, 0, 0); ex("raw.t2", 0, 1, 0, 0);
      nxt(); de(5, 1, 0, 0, 0, 0, 0); wb(5); ex("raw.t3", 1, 0, 0, 0);
      nxt(); ex("raw.t4", 0, 0, 0, 0);
      // rs2 port and its used flag
      nxt(); de(0, 0, 0, 0, 6, 1, 0); ex("rs2.w", 1, 0, 0, 0);
      nxt(); de(0, 0, 6, 1, 0, 0, 0); ex("rs2.used", 0, 1, 0, 0);
      nxt(); de(0, 0, 6, 0, 0, 0, 0); ex("rs2.unused", 1, 0, 0, 0);
      nxt(); wb(6); ex("rs2.ret", 0, 0, 0, 0);
      // x0 never busy
      nxt(); de(0, 0, 0, 0, 0, 1, 0); ex("x0.w", 1, 0, 0, 0);
      nxt(); de(0, 1, 0, 1, 0, 0, 0); ex("x0.rd", 1, 0, 0, 0);

      // taken branch: resolve two cycles after issue
      nxt(); de(1, 1, 2, 1, 0, 0, 1); ex("bt.iss", 1, 0, 0, 0);
      nxt(); de(3, 1, 0, 0, 0, 0, 0); ex("bt.wait", 0, 1, 0, 0);
      nxt(); de(3, 1, 0, 0, 0, 0, 0); br(1, 32'h0000_0100); ex("bt.res", 0, 1, 0, 0);
      nxt(); de(3, 1, 0, 0, 0, 0, 0); ex("bt.redir", 0, 0, 1, 1, 32'h0000_0100, 1);
      nxt(); de(3, 1, 0, 0, 0, 0, 0); br(1, 32'h0000_0200); ex("bt.idle", 1, 0, 0, 0);
      nxt(); ex("bt.ignored", 0, 0, 0, 0);

      // not-taken branch
      nxt(); de(1, 1, 2, 1, 0, 0, 1); ex("bn.iss", 1, 0, 0, 0);
      nxt(); de(3, 1, 0, 0, 0, 0, 0); ex("bn.wait", 0, 1, 0, 0);
      nxt(); de(3, 1, 0, 0, 0, 0, 0); br(0, 32'h0000_0300); ex("bn.res", 0, 1, 0, 0);
      nxt(); de(3, 1, 0, 0, 0, 0, 0); ex("bn.rel", 1, 0, 0, 0);

      // write-count saturation on x7
      for (int i = 0; i < 3; i++) begin
         nxt(); de(0, 0, 0, 0, 7, 1, 0); ex($sformatf("sat.w%0d", i), 1, 0, 0, 0);
      end
      nxt(); de(0, 0, 0, 0, 7, 1, 0); ex("sat.4th", 0, 1, 0, 0);
      nxt(); de(0, 0, 0, 0, 7, 1, 0); wb(7); ex("sat.wb", 0, 1, 0, 0);
      nxt(); de(0, 0, 0, 0, 7, 1, 0); wb(7); ex("sat.same", 1, 0, 0, 0);
      nxt(); de(0, 0, 0, 0, 7, 1, 0); ex("sat.fill", 1, 0, 0, 0);
      nxt(); de(0, 0, 0, 0, 7, 1, 0); ex("sat.full", 0, 1, 0, 0);
      nxt(); de(0, 0, 0, 0, 7, 0, 0); ex("sat.nowr", 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         nxt(); wb(7); ex($sformatf("sat.drain%0d", i), 0, 0, 0, 0);
      end
      nxt(); de(7, 1, 7, 1, 0, 0, 0); ex("sat.empty", 1, 0, 0, 0);

      // reset while waiting on a branch, with a pending write to x9
      nxt(); de(0, 0, 0, 0, 9, 1, 0); ex("rb.w9", 1, 0, 0, 0);
      nxt(); de(1, 1, 2, 1, 0, 0, 1); ex("rb.br", 1, 0, 0, 0);
      nxt(); de(9, 1, 0, 0, 0, 0, 0); ex("rb.wait", 0, 1, 0, 0);
      nxt(); reset = 1'b1; de(9, 1, 0, 0, 0, 0, 0); br(1, 32'h0000_0400);
      ex("rb.rst", 0, 0, 0, 0, '0, 1);
      nxt(); reset = 1'b0; de(9, 1, 0, 0, 0, 0, 0); ex("rb.after", 1, 0, 0, 0);
      nxt(); ex("rb.quiet", 0, 0, 0, 0);

      nxt();
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
